// File: rtl/issue_hazard_check.sv
// Register scoreboard between decode-2 and schedule: counts in-flight GPR writes and a CSR
// pending flag, and raises STALL on RAW, CSR or counter-saturation hazards.
module issue_hazard_check #(
  parameter int unsigned CNT_W = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       FLUSH,
  input  logic       MEM_WAIT,
  input  logic       CHECK_VALID,
  input  logic [4:0] CHECK_RS1,
  input  logic [4:0] CHECK_RS2,
  input  logic       CHECK_RS1_USE,
  input  logic       CHECK_RS2_USE,
  input  logic [4:0] CHECK_RD,
  input  logic       CHECK_RD_WRITE,
  input  logic       CHECK_CSR_READ,
  input  logic       CHECK_CSR_WRITE,
  input  logic       RETIRE_VALID,
  input  logic [4:0] RETIRE_RD,
  input  logic       RETIRE_CSR,
  output logic       STALL,
  output logic       BUSY_ANY,
  output logic       ERR
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  // Entry 0 exists only to keep indexing simple; it is never written.
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic             csr_pend_q, csr_pend_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             haz_rs1, haz_rs2, haz_csr, haz_sat;
  logic             issue;
  logic             inc, dec;

  always_comb begin
    haz_rs1 = CHECK_RS1_USE && (CHECK_RS1 != 5'd0) && (cnt_q[CHECK_RS1] != '0);
    haz_rs2 = CHECK_RS2_USE && (CHECK_RS2 != 5'd0) && (cnt_q[CHECK_RS2] != '0);
    haz_csr = (CHECK_CSR_READ || CHECK_CSR_WRITE) && csr_pend_q;
    haz_sat = CHECK_RD_WRITE && (CHECK_RD != 5'd0) && (cnt_q[CHECK_RD] == CntMax);
    STALL   = RST && CHECK_VALID && (haz_rs1 || haz_rs2 || haz_csr || haz_sat);
    issue   = CHECK_VALID && !STALL && !MEM_WAIT && !FLUSH;
  end

  always_comb begin
    cnt_d      = cnt_q;
    csr_pend_d = csr_pend_q;
    err_d      = err_q;
    inc        = 1'b0;
    dec        = 1'b0;
    if (FLUSH) begin
      // Flush kills every in-flight write; retires this cycle are dropped silently.
      for (int i = 0; i < 32; i++) begin
        cnt_d[i] = '0;
      end
      csr_pend_d = 1'b0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        inc = issue && CHECK_RD_WRITE && (CHECK_RD == 5'(i));
        dec = RETIRE_VALID && (RETIRE_RD == 5'(i));
        if (dec && (cnt_q[i] == '0)) begin
          err_d = 1'b1;
          dec   = 1'b0;
        end
        if (inc && !dec) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end else if (dec && !inc) begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
      if (RETIRE_CSR && !csr_pend_q) begin
        err_d = 1'b1;
      end
      // A new CSR write wins over a simultaneous CSR retire.
      if (issue && CHECK_CSR_WRITE) begin
        csr_pend_d = 1'b1;
      end else if (RETIRE_CSR) begin
        csr_pend_d = 1'b0;
      end
    end
    busy_d = csr_pend_d;
    for (int i = 1; i < 32; i++) begin
      busy_d = busy_d | (|cnt_d[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= '0;
      end
      csr_pend_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      csr_pend_q <= csr_pend_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign BUSY_ANY = busy_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_issue_hazard_check.sv
// Directed bench for issue_hazard_check with CNT_W=2 (saturation at 3 in-flight writes).
module tb_issue_hazard_check;

  logic       clk;
  logic       rst;
  logic       flush, mem_wait, chk_valid;
  logic [4:0] rs1, rs2, rd, ret_rd;
  logic       rs1_use, rs2_use, rd_write, csr_read, csr_write;
  logic       ret_valid, ret_csr;
  logic       stall, busy_any, err;

  int checks   = 0;
  int failures = 0;

  issue_hazard_check #(
    .CNT_W(2)
  ) u_dut (
    .CLK            (clk),
    .RST            (rst),
    .FLUSH          (flush),
    .MEM_WAIT       (mem_wait),
    .CHECK_VALID    (chk_valid),
    .CHECK_RS1      (rs1),
    .CHECK_RS2      (rs2),
    .CHECK_RS1_USE  (rs1_use),
    .CHECK_RS2_USE  (rs2_use),
    .CHECK_RD       (rd),
    .CHECK_RD_WRITE (rd_write),
    .CHECK_CSR_READ (csr_read),
    .CHECK_CSR_WRITE(csr_write),
    .RETIRE_VALID   (ret_valid),
    .RETIRE_RD      (ret_rd),
    .RETIRE_CSR     (ret_csr),
    .STALL          (stall),
    .BUSY_ANY       (busy_any),
    .ERR            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow after a further unit.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    flush = 0; mem_wait = 0; chk_valid = 0;
    rs1 = 0; rs2 = 0; rd = 0; rs1_use = 0; rs2_use = 0; rd_write = 0;
    csr_read = 0; csr_write = 0; ret_valid = 0; ret_rd = 0; ret_csr = 0;
  endtask

  task automatic put_write(input logic [4:0] r);
    idle(); chk_valid = 1; rd = r; rd_write = 1;
  endtask

  task automatic put_read1(input logic [4:0] r);
    idle(); chk_valid = 1; rs1 = r; rs1_use = 1;
  endtask

  initial begin
    idle();
    rst = 0;
    // Reset with a live write on the check bus.
    chk_valid = 1; rd = 5; rd_write = 1;
    settle();
    chk("reset_stall", stall, 1'b0);
    tick(); tick();
    settle();
    chk("reset_busy", busy_any, 1'b0);
    chk("reset_err", err, 1'b0);
    rst = 1;
    idle();
    tick();
    put_read1(5);
    settle();
    chk("reset_no_incr", stall, 1'b0);
    idle();

    // RAW hazard on x5.
    put_write(5);
    tick();
    put_read1(5);
    settle();
    chk("raw_stall_c1", stall, 1'b1);
    chk("raw_busy_set", busy_any, 1'b1);
    tick(); settle();
    chk("raw_stall_c2", stall, 1'b1);
    tick(); settle();
    chk("raw_stall_c3", stall, 1'b1);
    ret_valid = 1; ret_rd = 5;
    settle();
    chk("raw_no_bypass", stall, 1'b1);
    tick();
    ret_valid = 0;
    settle();
    chk("raw_stall_drop", stall, 1'b0);
    chk("raw_busy_clr", busy_any, 1'b0);
    idle();

    // Saturation of x7.
    put_write(7);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("sat_issue_free", stall, 1'b0);
      tick();
    end
    settle();
    chk("sat_4th_stall", stall, 1'b1);
    ret_valid = 1; ret_rd = 7;
    tick();
    ret_valid = 0;
    settle();
    chk("sat_after_retire", stall, 1'b0);
    tick(); settle();
    chk("sat_back_to_3", stall, 1'b1);
    idle();
    for (int i = 0; i < 3; i++) begin
      ret_valid = 1; ret_rd = 7;
      tick();
    end
    idle();
    settle();
    chk("sat_drained", busy_any, 1'b0);
    chk("sat_no_err", err, 1'b0);

    // Issue and retire of x9 in the same cycle.
    put_write(9);
    tick();
    put_write(9);
    ret_valid = 1; ret_rd = 9;
    tick();
    idle();
    chk_valid = 1; rs2 = 9; rs2_use = 1;
    settle();
    chk("simul_rs2_stall", stall, 1'b1);
    put_read1(0);
    settle();
    chk("x0_never_stalls", stall, 1'b0);
    idle();
    ret_valid = 1; ret_rd = 9;
    tick();
    idle();
    settle();
    chk("simul_drained", busy_any, 1'b0);
    chk("simul_no_err", err, 1'b0);

    // Flush with x3, x4 and a CSR write pending.
    put_write(3); tick();
    put_write(4); tick();
    idle(); chk_valid = 1; csr_write = 1; tick();
    idle(); chk_valid = 1; csr_read = 1;
    settle();
    chk("flush_pre_csr_stall", stall, 1'b1);
    chk("flush_pre_busy", busy_any, 1'b1);
    flush = 1; ret_valid = 1; ret_rd = 3;
    tick();
    flush = 0; ret_valid = 0;
    settle();
    chk("flush_busy_clr", busy_any, 1'b0);
    chk("flush_err_clr", err, 1'b0);
    chk("flush_csr_free", stall, 1'b0);
    put_read1(3);
    settle();
    chk("flush_x3_free", stall, 1'b0);
    // Retires at empty state during a flush must not raise ERR.
    idle(); flush = 1; ret_valid = 1; ret_rd = 20; ret_csr = 1;
    tick();
    idle();
    settle();
    chk("flush_drops_retire", err, 1'b0);

    // MEM_WAIT blocks issue only; then back-to-back issue.
    put_write(10); mem_wait = 1;
    tick();
    settle();
    chk("memwait_no_issue", busy_any, 1'b0);
    mem_wait = 0;
    settle();
    chk("b2b_first", stall, 1'b0);
    tick();
    put_write(11);
    settle();
    chk("b2b_second", stall, 1'b0);
    tick();
    put_read1(11);
    settle();
    chk("b2b_x11_pending", stall, 1'b1);
    idle(); mem_wait = 1; ret_valid = 1; ret_rd = 10; tick();
    ret_rd = 11; tick();
    idle();
    settle();
    chk("memwait_retires", busy_any, 1'b0);

    // Error paths and stickiness.
    ret_valid = 1; ret_rd = 12;
    tick();
    idle();
    settle();
    chk("err_gpr_underflow", err, 1'b1);
    ret_csr = 1;
    tick();
    idle();
    settle();
    chk("err_csr_still", err, 1'b1);
    flush = 1;
    tick();
    idle();
    settle();
    chk("err_sticky_flush", err, 1'b1);
    put_write(13);
    tick();
    put_read1(13);
    settle();
    chk("rst_pre_stall", stall, 1'b1);
    rst = 0;
    settle();
    chk("rst_gates_stall", stall, 1'b0);
    tick();
    settle();
    chk("rst_clears_err", err, 1'b0);
    chk("rst_clears_busy", busy_any, 1'b0);
    rst = 1;
    settle();
    chk("rst_clears_cnt", stall, 1'b0);
    idle();
    ret_csr = 1;
    tick();
    idle();
    settle();
    chk("err_csr_underflow", err, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_hazard_check.md
# issue_hazard_check

Register-scoreboard hazard checker that sits between decode stage 2 and the schedule stage, and produces the `STALL` the schedule stage consumes. For every instruction presented on the decode-side check bus, it counts writes in flight per destination register (x1–x31) and tracks one CSR pending flag. It asserts `STALL` while any source operand, or the CSR, depends on an unretired write, or while a destination counter is saturated. Writeback retirements decrement the counters. `FLUSH` discards all tracked state.

## Interface
- `CNT_W`, default 2: width of each per-register in-flight counter; max in-flight writes per register = 2^CNT_W − 1.
- `CLK` input, 1 bit: clock; all state updates on the rising edge.
- `RST` input, 1 bit: reset, synchronous, active-low.
- `FLUSH` input, 1 bit: pipeline flush; clears all tracking state.
- `MEM_WAIT` input, 1 bit: memory wait; blocks issue.
- `CHECK_VALID` input, 1 bit: check bus holds a real instruction.
- `CHECK_RS1` / `CHECK_RS2` input, 5 bits each: source register indices.
- `CHECK_RS1_USE` / `CHECK_RS2_USE` input, 1 bit each: the instruction reads that source.
- `CHECK_RD` input, 5 bits: destination register index.
- `CHECK_RD_WRITE` input, 1 bit: the instruction writes `CHECK_RD`.
- `CHECK_CSR_READ` / `CHECK_CSR_WRITE` input, 1 bit each: the instruction reads / writes any CSR.
- `RETIRE_VALID` input, 1 bit: writeback completes a GPR write this cycle.
- `RETIRE_RD` input, 5 bits: register being retired.
- `RETIRE_CSR` input, 1 bit: writeback completes a CSR write this cycle.
- `STALL` output, 1 bit: hold the check bus; combinational from state and check inputs.
- `BUSY_ANY` output, 1 bit: registered; any counter or CSR flag is non-zero.
- `ERR` output, 1 bit: registered, sticky; a retire arrived at a zero counter or clear CSR flag.

## Operation
- State: `cnt[1..31]`, each `CNT_W` bits; `csr_pend`, 1 bit; `ERR`. x0 is never tracked.
- A source hazard exists on rs1 when `CHECK_RS1_USE` is set, `CHECK_RS1` ≠ 0 and `cnt[CHECK_RS1]` ≠ 0. The rs2 hazard is defined the same way.
- A CSR hazard exists when `(CHECK_CSR_READ` or `CHECK_CSR_WRITE)` is set and `csr_pend` is 1.
- A saturation hazard exists when `CHECK_RD_WRITE` is set, `CHECK_RD` ≠ 0 and `cnt[CHECK_RD]` = 2^CNT_W − 1.
- `STALL` = `CHECK_VALID` and (any of the four hazards). `STALL` = 0 while `RST` is low.
- Issue fires when `CHECK_VALID` is set and `STALL`, `MEM_WAIT` and `FLUSH` are all low.
- On issue:
  - if `CHECK_RD_WRITE` is set and `CHECK_RD` ≠ 0, increment `cnt[CHECK_RD]`;
  - if `CHECK_CSR_WRITE` is set, set `csr_pend`.
- GPR retire: when `RETIRE_VALID` is set and `RETIRE_RD` ≠ 0, decrement `cnt[RETIRE_RD]`. If that counter is 0, it stays 0 and `ERR` is set.
- CSR retire: `RETIRE_CSR` clears `csr_pend`. If `csr_pend` is already 0, `ERR` is set.
- Issue and retire to the same register in the same cycle: the counter is unchanged (net 0).
- Issue of a CSR write together with `RETIRE_CSR`: `csr_pend` = 1.
- `FLUSH` has priority over issue and retire. All `cnt` entries and `csr_pend` are cleared. Retires arriving in the flush cycle are ignored and do not set `ERR`. `ERR` is preserved across flush.
- A flush kills every in-flight write, so no retire ever arrives for pre-flush instructions.
- `BUSY_ANY` is the OR of all next-state counters and `csr_pend`, registered.

## Timing
- Reset (`RST` low at an edge): all `cnt` = 0, `csr_pend` = 0, `ERR` = 0, `BUSY_ANY` = 0.
- Reset mid-operation discards all pending state in one cycle.
- `STALL` has 0-cycle latency from the check inputs.
- Counter effects appear one cycle after the issue or retire edge.
- There is no retire bypass. A consumer stalled on a register sees `STALL` drop in the cycle after the `RETIRE_VALID` edge, which is the minimum one-cycle bubble.
- `MEM_WAIT` only blocks issue. Retires are still processed and `STALL` is still computed.
- Back-to-back independent instructions issue every cycle with no bubble.

## Test plan
- **Reset:** drive `RST` low for 2 cycles with `CHECK_VALID`=1 and `CHECK_RD`=5. Required: `STALL`=0, `BUSY_ANY`=0, `ERR`=0, and no counter increments.
- **RAW hazard:**
  - Stimulus: issue a write to x5; next cycle present rs1=5 with `CHECK_RS1_USE`=1; 3 cycles later assert `RETIRE_VALID` with `RETIRE_RD`=5.
  - Required: `STALL`=1 until the cycle after the retire edge, then 0. `BUSY_ANY` goes 1 → 0 after the retire.
- **Saturation (CNT_W=2):**
  - Stimulus: issue 3 writes to x7, then a 4th.
  - Required: the 4th sees `STALL`=1. One retire of x7 drops `STALL` to 0 next cycle, and the 4th issues (counter back to 3).
- **Simultaneous events:**
  - Stimulus: with `cnt[9]`=1, issue a write to x9 and retire x9 in the same cycle.
  - Required: `cnt[9]` stays 1, so rs2=9 still stalls. A separately presented rs1=0 read never stalls.
- **Flush:**
  - Stimulus: with x3 and x4 pending and `csr_pend`=1, assert `FLUSH` together with `RETIRE_VALID` for x3.
  - Required: all state cleared, `BUSY_ANY`=0 next cycle, `ERR`=0, and a CSR read no longer stalls.
- **Error:**
  - Stimulus: retire x12 while `cnt[12]`=0, then assert `RETIRE_CSR` while `csr_pend`=0.
  - Required: `ERR`=1 from the cycle after the first event and stays 1 through a `FLUSH`. Only a `RST` low edge clears it.
